// File: rtl/udma_hyper_pkg.sv
// udma_hyper_pkg: command fields, burst-control bits and FSM states for the hyper 2D splitter.
package udma_hyper_pkg;
    localparam int HYPER_L2_AW = 12;
    localparam int HYPER_TS    = 16;

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic rw;
        logic addr_space;
        logic burst_type;
    } burst_ctrl_t;

    typedef struct packed {
        logic [HYPER_L2_AW-1:0] rx_addr;
        logic [HYPER_TS-1:0]    rx_size;
        logic [HYPER_L2_AW-1:0] tx_addr;
        logic [HYPER_TS-1:0]    tx_size;
        logic [31:0]            hyper_addr;
        logic [15:0]            intreg;
        burst_ctrl_t            ctrl;
        logic                   ext_act;
        logic [HYPER_TS-1:0]    ext_count;
        logic [HYPER_TS-1:0]    ext_stride;
        logic                   l2_act;
        logic [HYPER_TS-1:0]    l2_count;
        logic [HYPER_TS-1:0]    l2_stride;
    } cmd_t;
endpackage

// File: rtl/udma_hyper_twd_splitter.sv
// udma_hyper_twd_splitter: turns a queued hyperbus command into one or more PHY bursts.
// Strided 2D splitting exists only when UDMA_HYPER_TWD_SPLIT_EN is defined.
module udma_hyper_twd_splitter
    import udma_hyper_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                                       sys_clk_i,
    input  logic                                       rst_ni,
    input  logic [L2_AWIDTH_NOAL*2+TRANS_SIZE*6+52:0]  cmd_data_i,
    input  logic                                       cmd_valid_i,
    output logic                                       cmd_ready_o,
    output logic [L2_AWIDTH_NOAL-1:0]                  burst_l2_addr_o,
    output logic [31:0]                                burst_hyper_addr_o,
    output logic [TRANS_SIZE-1:0]                      burst_size_o,
    output logic [2:0]                                 burst_ctrl_o,
    output logic [15:0]                                burst_intreg_o,
    output logic                                       burst_last_o,
    output logic                                       burst_valid_o,
    input  logic                                       burst_ready_i,
    output logic                                       busy_o,
    output logic                                       done_o
);
    cmd_t                      cmd;
    state_e                    state_q, state_d;
    logic [L2_AWIDTH_NOAL-1:0] l2_addr_q, l2_addr_d;
    logic [31:0]               hyper_addr_q, hyper_addr_d;
    logic [TRANS_SIZE-1:0]     remaining_q, remaining_d, sel_size, size;
    burst_ctrl_t               ctrl_q, ctrl_d;
    logic [15:0]               intreg_q, intreg_d;
    logic                      done_q, done_d, fire, last;

    assign cmd      = cmd_t'(cmd_data_i);
    assign sel_size = cmd.ctrl.rw ? cmd.rx_size : cmd.tx_size;
    assign fire     = burst_valid_o && burst_ready_i;

`ifdef UDMA_HYPER_TWD_SPLIT_EN
    logic                  ext_act_q, ext_act_d, l2_act_q, l2_act_d;
    logic [TRANS_SIZE-1:0] chunk_q, chunk_d, ext_stride_q, ext_stride_d, l2_stride_q, l2_stride_d;

    assign last = remaining_q <= chunk_q;
    assign size = last ? remaining_q : chunk_q;
`else
    logic unused_split;

    assign unused_split = ^{cmd.ext_act, cmd.ext_count, cmd.ext_stride, cmd.l2_act, cmd.l2_count, cmd.l2_stride};
    assign last = 1'b1;
    assign size = remaining_q;
`endif

    always_comb begin
        state_d      = state_q;
        l2_addr_d    = l2_addr_q;
        hyper_addr_d = hyper_addr_q;
        remaining_d  = remaining_q;
        ctrl_d       = ctrl_q;
        intreg_d     = intreg_q;
        done_d       = 1'b0;
`ifdef UDMA_HYPER_TWD_SPLIT_EN
        chunk_d      = chunk_q;
        ext_act_d    = ext_act_q;
        l2_act_d     = l2_act_q;
        ext_stride_d = ext_stride_q;
        l2_stride_d  = l2_stride_q;
`endif
        if (state_q == IDLE) begin
            if (cmd_valid_i) begin
                l2_addr_d    = cmd.ctrl.rw ? cmd.rx_addr : cmd.tx_addr;
                hyper_addr_d = cmd.hyper_addr;
                remaining_d  = sel_size;
                ctrl_d       = cmd.ctrl;
                intreg_d     = cmd.intreg;
                // A zero-length command completes without ever leaving IDLE.
                state_d      = (sel_size == '0) ? IDLE : ISSUE;
                done_d       = (sel_size == '0);
`ifdef UDMA_HYPER_TWD_SPLIT_EN
                ext_act_d    = cmd.ext_act;
                l2_act_d     = cmd.l2_act;
                ext_stride_d = cmd.ext_stride;
                l2_stride_d  = cmd.l2_stride;
                chunk_d      = (cmd.ext_act && cmd.ext_count != '0) ? cmd.ext_count :
                               (cmd.l2_act && cmd.l2_count != '0) ? cmd.l2_count : sel_size;
`endif
            end
        end else if (fire) begin
            state_d = last ? IDLE : ISSUE;
`ifdef UDMA_HYPER_TWD_SPLIT_EN
            if (!last) begin
                remaining_d  = remaining_q - size;
                hyper_addr_d = hyper_addr_q + (ext_act_q ? 32'(ext_stride_q) : 32'(size));
                l2_addr_d    = l2_addr_q + (l2_act_q ? L2_AWIDTH_NOAL'(l2_stride_q) : L2_AWIDTH_NOAL'(size));
            end
`endif
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            l2_addr_q    <= '0;
            hyper_addr_q <= '0;
            remaining_q  <= '0;
            ctrl_q       <= '0;
            intreg_q     <= '0;
            done_q       <= 1'b0;
`ifdef UDMA_HYPER_TWD_SPLIT_EN
            chunk_q      <= '0;
            ext_act_q    <= 1'b0;
            l2_act_q     <= 1'b0;
            ext_stride_q <= '0;
            l2_stride_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            l2_addr_q    <= l2_addr_d;
            hyper_addr_q <= hyper_addr_d;
            remaining_q  <= remaining_d;
            ctrl_q       <= ctrl_d;
            intreg_q     <= intreg_d;
            done_q       <= done_d;
`ifdef UDMA_HYPER_TWD_SPLIT_EN
            chunk_q      <= chunk_d;
            ext_act_q    <= ext_act_d;
            l2_act_q     <= l2_act_d;
            ext_stride_q <= ext_stride_d;
            l2_stride_q  <= l2_stride_d;
`endif
        end
    end

    assign cmd_ready_o        = (state_q == IDLE);
    assign burst_valid_o      = (state_q == ISSUE);
    assign busy_o             = (state_q == ISSUE);
    assign burst_last_o       = burst_valid_o && last;
    assign burst_l2_addr_o    = l2_addr_q;
    assign burst_hyper_addr_o = hyper_addr_q;
    assign burst_size_o       = size;
    assign burst_ctrl_o       = ctrl_q;
    assign burst_intreg_o     = intreg_q;
    assign done_o             = done_q || (fire && last);
endmodule

// File: tb/tb_udma_hyper_twd_splitter.sv
// tb_udma_hyper_twd_splitter: randomized and directed checks of the splitter against a burst-list model.
module tb_udma_hyper_twd_splitter;
    localparam int AW = 12;
    localparam int TS = 16;
    localparam int CW = AW*2 + TS*6 + 53;
    localparam int BW = AW + 32 + TS + 1 + 3 + 16;
`ifdef UDMA_HYPER_TWD_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] rx_addr, tx_addr;
        logic [TS-1:0] rx_size, tx_size;
        logic [31:0]   hyper;
        logic [15:0]   intreg;
        logic          rw, aspace, bt, ea, la;
        logic [TS-1:0] ec, es, lc, ls;
    } tcmd_t;

    logic          sys_clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [CW-1:0] cmd_data_i = '0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] burst_l2_addr_o;
    logic [31:0]   burst_hyper_addr_o;
    logic [TS-1:0] burst_size_o;
    logic [2:0]    burst_ctrl_o;
    logic [15:0]   burst_intreg_o;
    logic          burst_last_o, burst_valid_o, busy_o, done_o;
    logic          burst_ready_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int ndone, done_cyc, first_vld;
    logic busy_seen;

    udma_hyper_twd_splitter #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
        .sys_clk_i(sys_clk_i), .rst_ni(rst_ni),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .burst_l2_addr_o(burst_l2_addr_o), .burst_hyper_addr_o(burst_hyper_addr_o),
        .burst_size_o(burst_size_o), .burst_ctrl_o(burst_ctrl_o), .burst_intreg_o(burst_intreg_o),
        .burst_last_o(burst_last_o), .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial forever #5 sys_clk_i = ~sys_clk_i;

    function automatic logic [BW-1:0] obs_now();
        return {burst_l2_addr_o, burst_hyper_addr_o, burst_size_o, burst_last_o, burst_ctrl_o, burst_intreg_o};
    endfunction

    function automatic logic [CW-1:0] pack(input tcmd_t c);
        return {c.rx_addr, c.rx_size, c.tx_addr, c.tx_size, c.hyper, c.intreg, c.rw, c.aspace, c.bt,
                c.ea, c.ec, c.es, c.la, c.lc, c.ls};
    endfunction

    function automatic tcmd_t base();
        tcmd_t c;
        c.rx_addr = '0; c.tx_addr = '0; c.rx_size = '0; c.tx_size = '0; c.hyper = '0;
        c.intreg = 16'($urandom()); c.rw = 1'b0; c.aspace = 1'($urandom()); c.bt = 1'($urandom());
        c.ea = 1'b0; c.la = 1'b0; c.ec = '0; c.es = '0; c.lc = '0; c.ls = '0;
        return c;
    endfunction

    // Expected burst list: walk the transfer in chunks, advancing each side by its stride or by the size.
    function automatic void model(input tcmd_t c);
        int unsigned rem, chunk, sz, l2;
        logic [31:0] hy;
        exp_q.delete();
        rem = c.rw ? c.rx_size : c.tx_size;
        l2  = c.rw ? c.rx_addr : c.tx_addr;
        hy  = c.hyper;
        chunk = rem;
        if (SPLIT && c.ea && c.ec != 0) chunk = c.ec;
        else if (SPLIT && c.la && c.lc != 0) chunk = c.lc;
        while (rem > 0) begin
            sz = (rem < chunk) ? rem : chunk;
            exp_q.push_back({AW'(l2), hy, TS'(sz), rem <= chunk, c.rw, c.aspace, c.bt, c.intreg});
            if (rem <= chunk) break;
            rem -= sz;
            hy = hy + ((SPLIT && c.ea) ? 32'(c.es) : sz);
            l2 = (l2 + ((SPLIT && c.la) ? c.ls : sz)) % (1 << AW);
        end
    endfunction

    task automatic accept(input tcmd_t c);
        cmd_data_i = pack(c);
        cmd_valid_i = 1'b1;
        burst_ready_i = 1'b0;
        @(posedge sys_clk_i); #1;
        cmd_valid_i = 1'b0;
        cmd_data_i = '0;
    endtask

    task automatic collect(input int stall_pct, input bit hold);
        obs_q.delete(); ndone = 0; done_cyc = -1; first_vld = -1; busy_seen = 1'b0;
        if (hold) begin
            cmd_valid_i = 1'b1;
            cmd_data_i = CW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        end
        for (int cyc = 0; cyc < 2000 && ndone == 0; cyc++) begin
            burst_ready_i = ($urandom_range(99) >= stall_pct);
            #1;
            busy_seen |= busy_o;
            if (burst_valid_o && first_vld < 0) first_vld = cyc;
            if (burst_valid_o && burst_ready_i) obs_q.push_back(obs_now());
            if (done_o) begin ndone++; done_cyc = cyc; end
            @(posedge sys_clk_i); #1;
        end
        cmd_valid_i = 1'b0;
        cmd_data_i = '0;
        burst_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(posedge sys_clk_i);
        #1 rst_ni = 1'b1;
        #1;
        vectors++;
        if ({cmd_ready_o, burst_valid_o, burst_last_o, busy_o, done_o} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset outputs: got rdy/vld/last/busy/done=%b, want 10000",
                     {cmd_ready_o, burst_valid_o, burst_last_o, busy_o, done_o});
        end
    endtask

    task automatic test_1d_write;
        tcmd_t c = base();
        c.tx_addr = 12'h100; c.tx_size = 16'd64; c.hyper = 32'h0000_4000;
        model(c); accept(c); collect(0, 1'b0);
        vectors++;
        if (obs_q.size() !== 1) begin miscompares++; $display("FAIL 1d count: got %0d, want 1", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL 1d burst %0d: got %h, want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if (first_vld !== 0 || done_cyc !== 0 || ndone !== 1) begin
            miscompares++;
            $display("FAIL 1d timing: got vld@%0d done@%0d n=%0d, want 0 0 1", first_vld, done_cyc, ndone);
        end
        vectors++;
        if (done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL 1d after: got done=%b rdy=%b, want 0 1", done_o, cmd_ready_o);
        end
    endtask

    task automatic test_2d_ext_read;
        tcmd_t c = base();
        c.rw = 1'b1; c.rx_addr = 12'h200; c.rx_size = 16'd40; c.tx_size = 16'd7;
        c.ea = 1'b1; c.ec = 16'd16; c.es = 16'h0100; c.hyper = 32'h0000_1000;
        model(c); accept(c); collect(25, 1'b0);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL 2d count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL 2d burst %0d: got %h, want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if (ndone !== 1) begin miscompares++; $display("FAIL 2d done: got %0d, want 1", ndone); end
    endtask

    task automatic test_backpressure;
        tcmd_t c = base();
        c.rw = 1'b1; c.rx_addr = 12'h0A0; c.rx_size = 16'd50; c.ea = 1'b1; c.ec = 16'd20;
        c.es = 16'h0040; c.hyper = 32'hFFFF_FFE0;
        model(c); accept(c);
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (burst_valid_o !== 1'b1 || obs_now() !== exp_q[0]) begin
                miscompares++;
                $display("FAIL stall cycle %0d: got vld=%b %h, want vld=1 %h", k, burst_valid_o, obs_now(), exp_q[0]);
            end
            @(posedge sys_clk_i); #1;
        end
        collect(40, 1'b0);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL stall count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall burst %0d: got %h, want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_l2_wrap;
        tcmd_t c = base();
        c.tx_addr = 12'hFF0; c.tx_size = 16'd32; c.la = 1'b1; c.lc = 16'd16; c.ls = 16'h0020;
        c.hyper = 32'h0000_0800;
        model(c); accept(c); collect(0, 1'b0);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL wrap count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL wrap burst %0d: got %h, want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_size;
        tcmd_t c = base();
        c.rw = 1'b1; c.rx_size = '0; c.tx_size = 16'd99; c.ea = 1'b1; c.ec = 16'd4;
        model(c); accept(c); collect(0, 1'b0);
        vectors++;
        if (obs_q.size() !== 0 || first_vld !== -1) begin
            miscompares++;
            $display("FAIL zero bursts: got %0d (vld@%0d), want none", obs_q.size(), first_vld);
        end
        vectors++;
        if (ndone !== 1 || done_cyc !== 0 || busy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL zero done: got n=%0d @%0d busy=%b, want 1 @0 busy=0", ndone, done_cyc, busy_seen);
        end
        vectors++;
        if (done_o !== 1'b0) begin miscompares++; $display("FAIL zero pulse width: got done=%b, want 0", done_o); end
    endtask

    task automatic test_ignore_in_issue;
        tcmd_t c = base();
        c.tx_addr = 12'h3C0; c.tx_size = 16'd70; c.la = 1'b1; c.lc = 16'd24; c.ls = 16'h0100;
        c.hyper = 32'h0001_0000;
        model(c); accept(c); collect(20, 1'b1);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL ignore count: got %0d, want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ignore burst %0d: got %h, want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore idle: got busy=%b rdy=%b, want 0 1", busy_o, cmd_ready_o);
        end
    endtask

    task automatic test_reset_mid_burst;
        tcmd_t c = base();
        c.tx_addr = 12'h040; c.tx_size = 16'd48; c.ea = 1'b1; c.ec = 16'd16; c.es = 16'h0040;
        c.hyper = 32'h0000_2000; c.intreg = 16'hA5A5;
        accept(c);
        if (SPLIT) begin
            burst_ready_i = 1'b1;
            @(posedge sys_clk_i); #1;
            burst_ready_i = 1'b0;
        end
        vectors++;
        if (burst_valid_o !== 1'b1) begin miscompares++; $display("FAIL pre-reset valid: got %b, want 1", burst_valid_o); end
        rst_ni = 1'b0;
        #1;
        vectors++;
        if ({burst_valid_o, burst_last_o, done_o, busy_o} !== 4'b0000 || obs_now() !== '0) begin
            miscompares++;
            $display("FAIL mid reset: got vld/last/done/busy=%b burst=%h, want 0000 0",
                     {burst_valid_o, burst_last_o, done_o, busy_o}, obs_now());
        end
        @(posedge sys_clk_i); @(posedge sys_clk_i); #1;
        rst_ni = 1'b1;
        #1;
        vectors++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post reset: got rdy=%b busy=%b, want 1 0", cmd_ready_o, busy_o);
        end
        c.tx_addr = 12'h7F0; c.tx_size = 16'd33; c.hyper = 32'h0000_3000;
        model(c); accept(c); collect(30, 1'b0);
        vectors++;
        if (obs_q.size() !== exp_q.size() || ndone !== 1) begin
            miscompares++;
            $display("FAIL post reset cmd: got %0d bursts n=%0d, want %0d 1", obs_q.size(), ndone, exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL post reset burst %0d: got %h, want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            tcmd_t c = base();
            c.rw = 1'($urandom()); c.rx_addr = AW'($urandom()); c.tx_addr = AW'($urandom());
            c.rx_size = TS'($urandom_range(0, 150)); c.tx_size = TS'($urandom_range(0, 150));
            c.hyper = $urandom();
            c.ea = 1'($urandom()); c.la = 1'($urandom());
            c.ec = $urandom_range(3) == 0 ? '0 : TS'($urandom_range(1, 40));
            c.lc = $urandom_range(3) == 0 ? '0 : TS'($urandom_range(1, 40));
            c.es = TS'($urandom()); c.ls = TS'($urandom());
            model(c); accept(c); collect(30, 1'($urandom()));
            vectors++;
            if (obs_q.size() !== exp_q.size() || ndone !== 1) begin
                miscompares++;
                $display("FAIL rand %0d: got %0d bursts n=%0d, want %0d 1", n, obs_q.size(), ndone, exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand %0d burst %0d: got %h, want %h", n, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_1d_write();
        test_2d_ext_read();
        test_backpressure();
        test_l2_wrap();
        test_zero_size();
        test_ignore_in_issue();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/udma_hyper_twd_splitter.md
UDMA_HYPER_TWD_SPLITTER -- requirements
Module: udma_hyper_twd_splitter

Interface
REQ-001 SHALL have parameter L2_AWIDTH_NOAL, default 12, L2 address width.
REQ-002 SHALL have parameter TRANS_SIZE, default 16, size, count and stride width.
REQ-003 SHALL have sys_clk_i  in  1  single clock. Reset is asynchronous and active-low.
REQ-004 SHALL have rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have cmd_data_i  in  L2_AWIDTH_NOAL*2+TRANS_SIZE*6+53  packed command (fields below).
REQ-006 SHALL have cmd_valid_i  in  1  command valid from the command-queue FIFO.
REQ-007 SHALL have cmd_ready_o  out  1  command accepted.
REQ-008 SHALL have burst_l2_addr_o  out  L2_AWIDTH_NOAL  L2 start address of the burst.
REQ-009 SHALL have burst_hyper_addr_o  out  32  hyper-side start address.
REQ-010 SHALL have burst_size_o  out  TRANS_SIZE  burst length in bytes.
REQ-011 SHALL have burst_ctrl_o  out  3  {rw, addr_space, burst_type}.
REQ-012 SHALL have burst_intreg_o  out  16  register-access data.
REQ-013 SHALL have burst_last_o  out  1  final burst of the command.
REQ-014 SHALL have burst_valid_o / burst_ready_i  out / in  1 / 1  burst handshake toward the PHY transaction controller.
REQ-015 SHALL have busy_o  out  1  command in flight; done_o  out  1  one-cycle pulse when a command completes.

Function
REQ-016 SHALL unpack cmd_data_i, MSB first, in this order: rx_addr, rx_size, tx_addr, tx_size, hyper_addr[32], intreg[16], rw, addr_space, burst_type, ext_act, ext_count, ext_stride, l2_act, l2_count, l2_stride (LSB).
REQ-017 SHALL use a two-state FSM, IDLE and ISSUE; cmd_ready_o=1 only in IDLE; a handshake in IDLE registers the fields and moves to ISSUE.
REQ-018 SHALL select operands by rw: rw=1 (read) uses rx_addr/rx_size; rw=0 uses tx_addr/tx_size; remaining := selected size.
REQ-019 SHALL define chunk as ext_count if ext_act and ext_count!=0, else l2_count if l2_act and l2_count!=0, else remaining (single burst).
REQ-020 SHALL assert burst_valid_o in ISSUE, one cycle after command accept, with burst_size_o = min(chunk, remaining) and burst_last_o = (remaining <= chunk).
REQ-021 SHALL keep all burst outputs stable while burst_valid_o=1 and burst_ready_i=0.
REQ-022 SHALL update state on a burst handshake that is not last: remaining -= size; hyper_addr += ext_stride if ext_act else size; l2_addr += l2_stride if l2_act else size.
REQ-023 SHALL make the hyper address wrap modulo 2^32 and the L2 address wrap modulo 2^L2_AWIDTH_NOAL.
REQ-024 SHALL, on a last-burst handshake, return to IDLE and pulse done_o in the same cycle.
REQ-025 SHALL, when the selected size is 0, accept the command, emit no burst, pulse done_o the next cycle and stay in IDLE.
REQ-026 SHALL ignore a new cmd_valid_i while in ISSUE, since cmd_ready_o=0.
REQ-027 SHALL set busy_o=1 in ISSUE and 0 otherwise.

Reset
REQ-028 SHALL, on rst_ni=0 at any time, mid-burst included, force IDLE, clear all registers, and drive burst_valid_o, burst_last_o, done_o and busy_o to 0; cmd_ready_o=1 after release.

Configuration
REQ-029 With macro UDMA_HYPER_TWD_SPLIT_EN defined, the block SHALL perform 2D splitting per REQ-019/REQ-022.
REQ-030 Without UDMA_HYPER_TWD_SPLIT_EN, the block SHALL ignore ext_act and l2_act, emit exactly one burst per nonzero command with burst_last_o=1, and synthesize no stride or count logic.

Structure
REQ-031 SHALL place the command field struct, the burst_ctrl struct and the FSM state enum in package udma_hyper_pkg.
REQ-032 SHALL include no sub-module; a single always_ff/always_comb pair suffices.

Verification
REQ-033 SHALL cover a 1D write: tx_addr=0x100, tx_size=64, no act -> one burst (0x100, 64, last=1), done_o pulse.
REQ-034 SHALL cover a 2D ext read: rx_size=40, ext_count=16, ext_stride=0x100, hyper_addr=0x1000 -> sizes 16,16,8; hyper 0x1000,0x1100,0x1200; L2 contiguous; last only on the third burst.
REQ-035 SHALL cover backpressure: burst_ready_i held low for 5 cycles -> outputs stable, no advance.
REQ-036 SHALL cover wrap: l2_addr=0xFF0, l2_act, l2_count=16, l2_stride=0x20, size=32 -> second L2 address is 0x010.
REQ-037 SHALL cover a zero-size command -> no burst_valid_o, done_o pulse, busy_o stays 0.
REQ-038 SHALL cover reset: rst_ni asserted during the second of three bursts -> IDLE, all outputs 0; the next command proceeds normally.
